// File: rtl/pwm_pkg.sv
// Shared definitions for the bit-plane PWM path: default geometry, index types
// and the commit state encoding.
package pwm_pkg;

  localparam int PWM_WIDTH = 16;
  localparam int NUM_PWM   = 4;

  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CHAN_W = chan_width(NUM_PWM);
  localparam int ADDR_W = addr_width(PWM_WIDTH);

  typedef logic [ADDR_W-1:0] pwm_addr_t;
  typedef logic [CHAN_W-1:0] chan_idx_t;

  typedef enum logic {
    COMMIT_IDLE  = 1'b0,
    COMMIT_ARMED = 1'b1
  } commit_state_t;

endpackage

// File: rtl/pwm_chan_buf.sv
// One channel of the double-buffered duty store: shadow register, active
// register and the bit-plane select for the PWM readout.
module pwm_chan_buf #(
  parameter int pwm_width = 16,
  parameter int addr_w    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [pwm_width-1:0] wr_data,
  input  logic                 xfer_en,
  input  logic [addr_w-1:0]    pwm_addr,
  output logic                 bit_out
);

  logic [pwm_width-1:0]   shadow;
  logic [pwm_width-1:0]   active;
  logic [2**addr_w-1:0]   padded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en)
        shadow <= wr_data;
      if (xfer_en)
        active <= shadow;
    end
  end

  // Zero-extend to the full address range so planes past pwm_width read as 0.
  always_comb begin
    padded                = '0;
    padded[pwm_width-1:0] = active;
  end

  assign bit_out = padded[pwm_addr];

endmodule

// File: rtl/pwm_frame_buf.sv
// Double-buffered duty store: host writes land in the shadow bank and are
// copied to the active bank only at a PWM frame boundary after a commit.
module pwm_frame_buf
  import pwm_pkg::*;
#(
  parameter int  pwm_width = PWM_WIDTH,
  parameter int  num_pwm   = NUM_PWM,
  localparam int chan_w    = chan_width(num_pwm),
  localparam int addr_w    = addr_width(pwm_width)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [chan_w-1:0]    wr_chan,
  input  logic [pwm_width-1:0] wr_data,
  input  logic                 commit,
  output logic                 commit_pending,
  output logic                 swap_done,
  input  logic                 latch_mem,
  input  logic [addr_w-1:0]    pwm_addr,
  output logic [num_pwm-1:0]   pwm_data
);

  commit_state_t state;
  commit_state_t state_next;
  logic          xfer;
  logic          wr_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COMMIT_IDLE;
      swap_done <= 1'b0;
    end else begin
      state     <= state_next;
      swap_done <= xfer;
    end
  end

  // A latch_mem arriving with the commit only arms; the copy waits for the next frame.
  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    case (state)
      COMMIT_IDLE: begin
        if (commit)
          state_next = COMMIT_ARMED;
      end
      COMMIT_ARMED: begin
        if (latch_mem) begin
          xfer       = 1'b1;
          state_next = COMMIT_IDLE;
        end
      end
      default: state_next = COMMIT_IDLE;
    endcase
  end

  assign commit_pending = (state == COMMIT_ARMED);
  assign wr_ready       = !commit_pending;
  assign wr_accept      = wr_valid && wr_ready;

  // Out-of-range channel indices match no instance, so such writes vanish.
  for (genvar c = 0; c < num_pwm; c++) begin : g_chan
    pwm_chan_buf #(
      .pwm_width (pwm_width),
      .addr_w    (addr_w)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_accept && (wr_chan == chan_w'(c))),
      .wr_data  (wr_data),
      .xfer_en  (xfer),
      .pwm_addr (pwm_addr),
      .bit_out  (pwm_data[c])
    );
  end

endmodule
